// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, fixed-latency memory between instruction fetch and MEM-stage data access.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on ties instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              register_reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       owner_d;
  logic       d_req;
  logic       if_cand;
  logic       d_cand;
  logic       grant_d;
  logic       finish;

  // A port's own done pulse masks its still-held request, so it is not regranted in the completion cycle.
  always_comb begin
    d_req    = d_read | d_write;
    if_stall = if_req & ~if_done;
    d_stall  = d_req & ~d_done;
    if_cand  = if_stall;
    d_cand   = d_stall;
    finish   = ((state == ISSUE) && (LATENCY == 1)) ||
               ((state == WAIT) && (cnt == 4'd1));
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_comb grant_d = d_cand & (~if_cand | ~last_d);

  always_ff @(posedge clk) begin
    if (register_reset) begin
      last_d <= 1'b0;
    end else if ((state == IDLE) && (d_cand || if_cand)) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb grant_d = d_cand;
`endif

  always_ff @(posedge clk) begin
    if (register_reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      owner_d  <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      m_en    <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_cand || if_cand) begin
            owner_d <= grant_d;
            m_en    <= 1'b1;
            m_we    <= grant_d & d_write;
            m_addr  <= grant_d ? d_addr : if_addr;
            m_wdata <= grant_d ? d_wdata : '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'(LATENCY - 1);
          state <= (LATENCY == 1) ? IDLE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Completion: capture read data for the owner; its done pulse lands in the following IDLE cycle.
      if (finish) begin
        if (owner_d) begin
          d_done  <= 1'b1;
          d_rdata <= m_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= m_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
        end
      end
    end
  end

endmodule
